image_src: RTL

IMAGE_SRC -- requirements
Module: image_src

---
 rtl/image_src.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/image_src.sv
// Test-pattern image source: streams a width x height frame of generated pixels,
// then emits an end-of-frame marker and a done pulse, honouring downstream backpressure.
module image_src #(
    parameter int DW_OUT = 32,
    parameter int CW     = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic [CW-1:0]     width_in,
    input  logic [CW-1:0]     height_in,
    input  logic [1:0]        mode_in,
    input  logic [DW_OUT-1:0] const_in,
    output logic [DW_OUT-1:0] im_data_out,
    output logic              im_valid_out,
    output logic              im_end_out,
    input  logic              im_busy_in,
    output logic              src_busy_out,
    output logic              done_out
);

    localparam int HW = DW_OUT / 2;
    localparam int IW = 2 * CW;

    typedef logic [CW-1:0]     coord_t;
    typedef logic [IW-1:0]     idx_t;
    typedef logic [HW-1:0]     half_t;
    typedef logic [DW_OUT-1:0] out_t;

    typedef enum logic [1:0] {IDLE, RUN, END} state_t;

    state_t     state_q;
    coord_t     x_q, y_q, width_q, height_q;
    idx_t       idx_q;
    logic [1:0] mode_q;
    out_t       const_q;
    out_t       data_q;
    logic       valid_q, end_q, done_q;

    coord_t     x_d, y_d;
    idx_t       idx_d;
    logic       lastX, lastPix;

    function automatic out_t pixelFor(input logic [1:0] mode, input coord_t px,
                                      input coord_t py, input idx_t pidx,
                                      input out_t cval);
        out_t r;
        r = '0;
        case (mode)
            2'd0: r = out_t'(pidx);
            2'd1: begin
                r[HW-1:0]    = half_t'(px);
                r[2*HW-1:HW] = half_t'(py);
            end
            2'd2: r = cval;
            default: r = (px[0] ^ py[0]) ? '1 : '0;
        endcase
        return r;
    endfunction

    // Coordinates of the pixel that follows the one currently presented.
    always_comb begin
        lastX   = (x_q == width_q - coord_t'(1));
        lastPix = lastX && (y_q == height_q - coord_t'(1));
        x_d     = lastX ? '0 : x_q + coord_t'(1);
        y_d     = lastX ? y_q + coord_t'(1) : y_q;
        idx_d   = idx_q + idx_t'(1);
    end

    // Outputs are registered and computed for the pixel being loaded, so the
    // first beat appears the cycle after start and a stall simply holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            idx_q    <= '0;
            width_q  <= '0;
            height_q <= '0;
            mode_q   <= '0;
            const_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            end_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_in) begin
                        if (width_in != '0 && height_in != '0) begin
                            width_q  <= width_in;
                            height_q <= height_in;
                            mode_q   <= mode_in;
                            const_q  <= const_in;
                            x_q      <= '0;
                            y_q      <= '0;
                            idx_q    <= '0;
                            data_q   <= pixelFor(mode_in, '0, '0, '0, const_in);
                            valid_q  <= 1'b1;
                            state_q  <= RUN;
                        end else begin
                            end_q   <= 1'b1;
                            state_q <= END;
                        end
                    end
                end
                RUN: begin
                    if (!im_busy_in) begin
                        if (lastPix) begin
                            valid_q <= 1'b0;
                            data_q  <= '0;
                            end_q   <= 1'b1;
                            state_q <= END;
                        end else begin
                            x_q    <= x_d;
                            y_q    <= y_d;
                            idx_q  <= idx_d;
                            data_q <= pixelFor(mode_q, x_d, y_d, idx_d, const_q);
                        end
                    end
                end
                END: begin
                    if (!im_busy_in) begin
                        end_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign im_data_out  = data_q;
    assign im_valid_out = valid_q;
    assign im_end_out   = end_q;
    assign done_out     = done_q;
    assign src_busy_out = (state_q != IDLE);

endmodule
